// File: rtl/rs_alu_issue_if.sv
// Dispatch, CDB and issue-bundle signals of the ALU reservation station.
// The issue opcode is named op_type because "type" is a reserved word.
interface rs_alu_issue_if #(
  parameter int RS_SIZE   = 8,
  parameter int OP_WIDTH  = 7,
  parameter int VAL_WIDTH = 32,
  parameter int TAG_WIDTH = 4
);
  localparam int CNT_W = $clog2(RS_SIZE) + 1;

  logic                 disp_valid;
  logic [OP_WIDTH-1:0]  disp_type;
  logic [VAL_WIDTH-1:0] disp_vj, disp_vk;
  logic                 disp_qj_busy, disp_qk_busy;
  logic [TAG_WIDTH-1:0] disp_qj, disp_qk;
  logic [TAG_WIDTH-1:0] disp_entry;
  logic [31:0]          disp_pc;

  logic                 rs_full;
  logic [CNT_W-1:0]     rs_count;

  logic                 cdb0_valid, cdb1_valid;
  logic [TAG_WIDTH-1:0] cdb0_entry, cdb1_entry;
  logic [VAL_WIDTH-1:0] cdb0_val, cdb1_val;

  logic                 execute;
  logic [OP_WIDTH-1:0]  op_type;
  logic [VAL_WIDTH-1:0] val1, val2;
  logic [TAG_WIDTH-1:0] entry;
  logic [31:0]          nowPC;

  modport master (
    output disp_valid, disp_type, disp_vj, disp_vk, disp_qj_busy, disp_qk_busy,
           disp_qj, disp_qk, disp_entry, disp_pc,
           cdb0_valid, cdb0_entry, cdb0_val, cdb1_valid, cdb1_entry, cdb1_val,
    input  rs_full, rs_count, execute, op_type, val1, val2, entry, nowPC
  );

  modport slave (
    input  disp_valid, disp_type, disp_vj, disp_vk, disp_qj_busy, disp_qk_busy,
           disp_qj, disp_qk, disp_entry, disp_pc,
           cdb0_valid, cdb0_entry, cdb0_val, cdb1_valid, cdb1_entry, cdb1_val,
    output rs_full, rs_count, execute, op_type, val1, val2, entry, nowPC
  );
endinterface

// File: rtl/rs_alu_issue.sv
// ALU reservation station: dispatch to lowest free slot, CDB wakeup/bypass,
// lowest-index ready select, one registered issue per cycle.
module rs_alu_issue #(
  parameter int RS_SIZE   = 8,
  parameter int OP_WIDTH  = 7,
  parameter int VAL_WIDTH = 32,
  parameter int TAG_WIDTH = 4
) (
  input  logic clk,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic flush,
  rs_alu_issue_if.slave bus
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0]                r_busy, r_qjb, r_qkb;
  logic [RS_SIZE-1:0][OP_WIDTH-1:0]  r_type;
  logic [RS_SIZE-1:0][VAL_WIDTH-1:0] r_vj, r_vk;
  logic [RS_SIZE-1:0][TAG_WIDTH-1:0] r_qj, r_qk, r_entry;
  logic [RS_SIZE-1:0][31:0]          r_pc;

  logic                 r_execute;
  logic [OP_WIDTH-1:0]  r_op_type;
  logic [VAL_WIDTH-1:0] r_val1, r_val2;
  logic [TAG_WIDTH-1:0] r_out_entry;
  logic [31:0]          r_now_pc;

  logic [IDX_W-1:0] w_free_idx, w_sel_idx;
  logic             w_free_ok, w_sel_ok, w_full, w_disp_acc;
  logic [CNT_W-1:0] w_count;

  logic [RS_SIZE-1:0]                w_load, w_nqjb, w_nqkb;
  logic [RS_SIZE-1:0][VAL_WIDTH-1:0] w_nvj, w_nvk;

  // cdb0 is checked first so it wins when both ports carry the same tag.
  function automatic logic [VAL_WIDTH:0] snoop(
    input logic pend, input logic [TAG_WIDTH-1:0] q, input logic [VAL_WIDTH-1:0] v,
    input logic c0v, input logic [TAG_WIDTH-1:0] c0e, input logic [VAL_WIDTH-1:0] c0d,
    input logic c1v, input logic [TAG_WIDTH-1:0] c1e, input logic [VAL_WIDTH-1:0] c1d);
    if (pend && c0v && c0e == q)      snoop = {1'b0, c0d};
    else if (pend && c1v && c1e == q) snoop = {1'b0, c1d};
    else                              snoop = {pend, v};
  endfunction

  always_comb begin
    w_free_ok  = 1'b0;
    w_free_idx = '0;
    w_sel_ok   = 1'b0;
    w_sel_idx  = '0;
    w_count    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_ok  = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_busy[i] && !r_qjb[i] && !r_qkb[i]) begin
        w_sel_ok  = 1'b1;
        w_sel_idx = IDX_W'(i);
      end
      w_count = w_count + CNT_W'(r_busy[i]);
    end
  end

  assign w_full     = !w_free_ok;
  assign w_disp_acc = bus.disp_valid && !w_full && rdy_in && !flush;

  // Dispatch bypass and stored-operand wakeup share one snoop path per slot.
  always_comb begin
    w_load = '0;
    w_nqjb = '0;
    w_nqkb = '0;
    w_nvj  = '0;
    w_nvk  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_load[i] = w_disp_acc && (w_free_idx == IDX_W'(i));
      {w_nqjb[i], w_nvj[i]} = snoop(
        w_load[i] ? bus.disp_qj_busy : r_qjb[i],
        w_load[i] ? bus.disp_qj      : r_qj[i],
        w_load[i] ? bus.disp_vj      : r_vj[i],
        bus.cdb0_valid, bus.cdb0_entry, bus.cdb0_val,
        bus.cdb1_valid, bus.cdb1_entry, bus.cdb1_val);
      {w_nqkb[i], w_nvk[i]} = snoop(
        w_load[i] ? bus.disp_qk_busy : r_qkb[i],
        w_load[i] ? bus.disp_qk      : r_qk[i],
        w_load[i] ? bus.disp_vk      : r_vk[i],
        bus.cdb0_valid, bus.cdb0_entry, bus.cdb0_val,
        bus.cdb1_valid, bus.cdb1_entry, bus.cdb1_val);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_busy      <= '0;
      r_execute   <= 1'b0;
      r_op_type   <= '0;
      r_val1      <= '0;
      r_val2      <= '0;
      r_out_entry <= '0;
      r_now_pc    <= '0;
    end else if (flush) begin
      r_busy    <= '0;
      r_execute <= 1'b0;
    end else if (rdy_in) begin
      r_execute <= w_sel_ok;
      if (w_sel_ok) begin
        r_op_type   <= r_type[w_sel_idx];
        r_val1      <= r_vj[w_sel_idx];
        r_val2      <= r_vk[w_sel_idx];
        r_out_entry <= r_entry[w_sel_idx];
        r_now_pc    <= r_pc[w_sel_idx];
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (w_load[i]) begin
          r_busy[i]  <= 1'b1;
          r_type[i]  <= bus.disp_type;
          r_qj[i]    <= bus.disp_qj;
          r_qk[i]    <= bus.disp_qk;
          r_entry[i] <= bus.disp_entry;
          r_pc[i]    <= bus.disp_pc;
          r_qjb[i]   <= w_nqjb[i];
          r_qkb[i]   <= w_nqkb[i];
          r_vj[i]    <= w_nvj[i];
          r_vk[i]    <= w_nvk[i];
        end else if (r_busy[i]) begin
          if (w_sel_ok && w_sel_idx == IDX_W'(i)) r_busy[i] <= 1'b0;
          r_qjb[i] <= w_nqjb[i];
          r_qkb[i] <= w_nqkb[i];
          r_vj[i]  <= w_nvj[i];
          r_vk[i]  <= w_nvk[i];
        end
      end
    end
  end

  assign bus.rs_full  = w_full;
  assign bus.rs_count = w_count;
  assign bus.execute  = r_execute;
  assign bus.op_type  = r_op_type;
  assign bus.val1     = r_val1;
  assign bus.val2     = r_val2;
  assign bus.entry    = r_out_entry;
  assign bus.nowPC    = r_now_pc;
endmodule

// File: tb/tb_rs_alu_issue.sv
// Directed bench for rs_alu_issue: latency, wakeup, bypass, full/refill,
// select order, flush, stall and reset behaviour.
module tb_rs_alu_issue;
  logic clk = 1'b0;
  logic rst_in, rdy_in, flush;
  int   n_cmp = 0;
  int   n_err = 0;

  rs_alu_issue_if #(.RS_SIZE(8), .OP_WIDTH(7), .VAL_WIDTH(32), .TAG_WIDTH(4)) bus ();

  rs_alu_issue #(.RS_SIZE(8), .OP_WIDTH(7), .VAL_WIDTH(32), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are stable 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid   = 1'b0;
    bus.disp_type    = '0;
    bus.disp_vj      = '0;
    bus.disp_vk      = '0;
    bus.disp_qj_busy = 1'b0;
    bus.disp_qk_busy = 1'b0;
    bus.disp_qj      = '0;
    bus.disp_qk      = '0;
    bus.disp_entry   = '0;
    bus.disp_pc      = '0;
    bus.cdb0_valid   = 1'b0;
    bus.cdb0_entry   = '0;
    bus.cdb0_val     = '0;
    bus.cdb1_valid   = 1'b0;
    bus.cdb1_entry   = '0;
    bus.cdb1_val     = '0;
  endtask

  task automatic disp(input logic [6:0] ty, input logic [31:0] vj, input logic [31:0] vk,
                      input logic qjb, input logic [3:0] qj, input logic qkb, input logic [3:0] qk,
                      input logic [3:0] ent, input logic [31:0] pc);
    bus.disp_valid   = 1'b1;
    bus.disp_type    = ty;
    bus.disp_vj      = vj;
    bus.disp_vk      = vk;
    bus.disp_qj_busy = qjb;
    bus.disp_qj      = qj;
    bus.disp_qk_busy = qkb;
    bus.disp_qk      = qk;
    bus.disp_entry   = ent;
    bus.disp_pc      = pc;
  endtask

  initial begin
    idle();
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    step(); step();
    chk("rst_execute", 64'(bus.execute), 64'd0);
    chk("rst_count",   64'(bus.rs_count), 64'd0);
    chk("rst_full",    64'(bus.rs_full), 64'd0);
    chk("rst_bundle",  {bus.val1, bus.val2}, 64'd0);
    chk("rst_misc",    {bus.op_type, bus.entry, bus.nowPC}, 64'd0);
    rst_in = 1'b0;

    // Ready add: two-edge latency, single-cycle pulse
    disp(7'b0000000, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 32'h100);
    step(); idle();
    chk("add_e0_exec", 64'(bus.execute), 64'd0);
    chk("add_e0_cnt",  64'(bus.rs_count), 64'd1);
    step();
    chk("add_exec",  64'(bus.execute), 64'd1);
    chk("add_vals",  {bus.val1, bus.val2}, {32'd5, 32'd7});
    chk("add_entry", 64'(bus.entry), 64'd3);
    chk("add_pc",    64'(bus.nowPC), 64'h100);
    chk("add_cnt",   64'(bus.rs_count), 64'd0);
    step();
    chk("add_pulse", 64'(bus.execute), 64'd0);
    chk("add_hold",  64'(bus.val1), 64'd5);

    // Pending qj woken by cdb1 three cycles later
    disp(7'b0010010, 32'd0, 32'd9, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5, 32'h200);
    step(); idle();
    step(); step();
    chk("wk_wait", 64'(bus.execute), 64'd0);
    chk("wk_cnt",  64'(bus.rs_count), 64'd1);
    bus.cdb1_valid = 1'b1; bus.cdb1_entry = 4'd2; bus.cdb1_val = 32'h10;
    step(); idle();
    chk("wk_e0_exec", 64'(bus.execute), 64'd0);
    step();
    chk("wk_exec", 64'(bus.execute), 64'd1);
    chk("wk_vals", {bus.val1, bus.val2}, {32'h10, 32'd9});
    chk("wk_misc", {bus.op_type, bus.entry}, {7'b0010010, 4'd5});
    step();

    // Dispatch-cycle bypass on qk, cdb0 beats cdb1 on equal tags
    disp(7'b0000001, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6, 4'd9, 32'h300);
    bus.cdb0_valid = 1'b1; bus.cdb0_entry = 4'd6; bus.cdb0_val = 32'hAB;
    bus.cdb1_valid = 1'b1; bus.cdb1_entry = 4'd6; bus.cdb1_val = 32'hCD;
    step(); idle();
    step();
    chk("byp_exec", 64'(bus.execute), 64'd1);
    chk("byp_vals", {bus.val1, bus.val2}, {32'd1, 32'hAB});
    step();

    // Fill all eight slots with pending operands (slot i waits on tag i)
    for (int i = 0; i < 8; i++) begin
      disp(7'b0000000, 32'd0, 32'(i), 1'b1, 4'(i), 1'b0, 4'd0, 4'(i), 32'(i));
      step();
    end
    idle();
    chk("fill_full", 64'(bus.rs_full), 64'd1);
    chk("fill_cnt",  64'(bus.rs_count), 64'd8);
    disp(7'b0000000, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'hF, 32'hF0);
    step(); idle();
    chk("ninth_cnt",  64'(bus.rs_count), 64'd8);
    chk("ninth_exec", 64'(bus.execute), 64'd0);
    bus.cdb0_valid = 1'b1; bus.cdb0_entry = 4'd3; bus.cdb0_val = 32'h33;
    step(); idle();
    step();
    chk("full_wk_exec",  64'(bus.execute), 64'd1);
    chk("full_wk_entry", 64'(bus.entry), 64'd3);
    chk("full_wk_val",   {bus.val1, bus.val2}, {32'h33, 32'd3});
    chk("full_wk_free",  {63'd0, bus.rs_full}, 64'd0);
    chk("full_wk_cnt",   64'(bus.rs_count), 64'd7);
    disp(7'b0000000, 32'hE1, 32'hE2, 1'b0, 4'd0, 1'b0, 4'd0, 4'hE, 32'hE0);
    step(); idle();
    chk("refill_cnt",  64'(bus.rs_count), 64'd8);
    chk("refill_exec", 64'(bus.execute), 64'd0);
    step();
    chk("refill_issue", {63'd0, bus.execute}, 64'd1);
    chk("refill_entry", {bus.entry, bus.val1}, {4'hE, 32'hE1});

    // Make slot 0 eligible, then flush before it can issue
    bus.cdb1_valid = 1'b1; bus.cdb1_entry = 4'd0; bus.cdb1_val = 32'h55;
    step(); idle();
    flush = 1'b1;
    disp(7'b0000000, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 32'd0);
    step(); idle(); flush = 1'b0;
    chk("flush_exec", 64'(bus.execute), 64'd0);
    chk("flush_cnt",  64'(bus.rs_count), 64'd0);
    chk("flush_full", 64'(bus.rs_full), 64'd0);
    step();
    chk("flush_after", 64'(bus.execute), 64'd0);

    // Slots 1 and 4 wake together: lower index issues first
    for (int i = 0; i < 5; i++) begin
      disp(7'b0000000, 32'd0, 32'(i), 1'b1, ((i == 1) || (i == 4)) ? 4'd9 : 4'hA,
           1'b0, 4'd0, 4'(i), 32'h400 + 32'(i));
      step();
    end
    idle();
    bus.cdb0_valid = 1'b1; bus.cdb0_entry = 4'd9; bus.cdb0_val = 32'h99;
    step(); idle();
    step();
    chk("ord_first",  {bus.execute, bus.entry}, {1'b1, 4'd1});
    step();
    chk("ord_second", {bus.execute, bus.entry}, {1'b1, 4'd4});
    chk("ord_pc",     64'(bus.nowPC), 64'h404);
    step();
    chk("ord_done", 64'(bus.execute), 64'd0);
    chk("ord_cnt",  64'(bus.rs_count), 64'd3);
    flush = 1'b1; rdy_in = 1'b0;
    step(); flush = 1'b0; rdy_in = 1'b1;
    chk("flush_nrdy_cnt", 64'(bus.rs_count), 64'd0);

    // Stall for three cycles while an issue is on the outputs
    disp(7'b0000000, 32'h70, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7, 32'h700);
    step();
    disp(7'b0000000, 32'h80, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8, 32'h800);
    step();
    rdy_in = 1'b0;
    disp(7'b0000000, 32'h90, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9, 32'h900);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_bundle", {bus.execute, bus.entry, bus.val1}, {1'b1, 4'd7, 32'h70});
      chk("stall_cnt",    64'(bus.rs_count), 64'd1);
    end
    idle(); rdy_in = 1'b1;
    step();
    chk("resume_bundle", {bus.execute, bus.entry, bus.val1}, {1'b1, 4'd8, 32'h80});
    chk("resume_cnt",    64'(bus.rs_count), 64'd0);
    step();
    chk("resume_idle", 64'(bus.execute), 64'd0);

    // Reset mid-operation discards queued work
    disp(7'b0000000, 32'hC1, 32'hC2, 1'b0, 4'd0, 1'b0, 4'd0, 4'hC, 32'hC00);
    step();
    disp(7'b0000000, 32'hD1, 32'hD2, 1'b1, 4'd5, 1'b0, 4'd0, 4'hD, 32'hD00);
    rst_in = 1'b1; flush = 1'b1;
    step(); idle(); rst_in = 1'b0; flush = 1'b0;
    chk("mrst_exec",   64'(bus.execute), 64'd0);
    chk("mrst_cnt",    64'(bus.rs_count), 64'd0);
    chk("mrst_bundle", {bus.val1, bus.entry, bus.nowPC[27:0]}, 64'd0);
    bus.cdb0_valid = 1'b1; bus.cdb0_entry = 4'd5; bus.cdb0_val = 32'h1;
    step(); idle();
    step();
    chk("mrst_none", {bus.execute, bus.rs_count}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
